// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch states, instruction field slices.
// Imported by the fetch unit and its next-PC calculator.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_SW    = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ISSUE
  } fetch_state_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int FN_HI  = 3;
  localparam int FN_LO  = 0;
  localparam int JT_HI  = 11;
  localparam int JT_LO  = 0;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the retiring instruction.
// Priority: jump, then taken branch, then pc+1.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [15:0]     i_ir,
  input  logic            i_jump,
  input  logic            i_branch,
  input  logic            i_zero,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_pc_plus1;
  logic [PC_W-1:0] w_br_tgt;
  logic [PC_W-1:0] w_jmp_tgt;
  logic [3:0]      w_opc;
  logic            w_taken;

  assign w_opc      = i_ir[OPC_HI:OPC_LO];
  assign w_pc_plus1 = i_pc + PC_W'(1);
  assign w_br_tgt   = w_pc_plus1
                    + {{(PC_W-4){i_ir[FN_HI]}},
                       i_ir[FN_HI:FN_LO]};
  assign w_jmp_tgt  = {w_pc_plus1[PC_W-1:JT_HI+1],
                       i_ir[JT_HI:JT_LO]};

  always_comb begin
    w_taken = 1'b0;
    unique case (w_opc)
      OP_BEQ:  w_taken = i_branch & i_zero;
      OP_BNE:  w_taken = i_branch & ~i_zero;
      default: w_taken = 1'b0;
    endcase
  end

  // jump and a taken branch may both be set; jump wins
  always_comb begin
    o_next_pc = w_pc_plus1;
    priority case (1'b1)
      i_jump:  o_next_pc = w_jmp_tgt;
      w_taken: o_next_pc = w_br_tgt;
      default: o_next_pc = w_pc_plus1;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// CPU front end: PC, single-outstanding fetch FSM and instruction register.
// Presents the held instruction until retire, then moves to the next PC.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  output logic            instr_valid,
  output logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [3:0]      funct,
  output logic [PC_W-1:0] pc,
  input  logic            retire,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            zero_i
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [PC_W-1:0] w_next_pc;

  next_pc_calc #(
    .PC_W(PC_W)
  ) u_npc (
    .i_pc     (r_pc),
    .i_ir     (r_ir),
    .i_jump   (jump_i),
    .i_branch (branch_i),
    .i_zero   (zero_i),
    .o_next_pc(w_next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  w_state_nxt = REQ;
      REQ:   if (imem_gnt)    w_state_nxt = WAIT;
      WAIT:  if (imem_rvalid) w_state_nxt = ISSUE;
      ISSUE: if (retire)      w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= 16'h0000;
    end else if (r_state == WAIT && imem_rvalid) begin
      r_ir <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (r_state == ISSUE && retire) begin
      r_pc <= w_next_pc;
    end
  end

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ISSUE);
  assign instr       = r_ir;
  assign opcode      = r_ir[OPC_HI:OPC_LO];
  assign funct       = r_ir[FN_HI:FN_LO];
  assign pc          = r_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table, hand sequences
// and random fetches against an arithmetic next-PC model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic [15:0] pc;
  logic        retire;
  logic        branch_i;
  logic        jump_i;
  logic        zero_i;

  instruction_fetch_unit #(
    .PC_W(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .opcode     (opcode),
    .funct      (funct),
    .pc         (pc),
    .retire     (retire),
    .branch_i   (branch_i),
    .jump_i     (jump_i),
    .zero_i     (zero_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n)
      assert (!(imem_gnt && imem_rvalid))
        else $error("protocol violation: gnt and rvalid together");

  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] m_pc;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
    bit          j;
    bit          b;
    bit          z;
    logic [15:0] nx;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] p,
      input logic [15:0] ir, input bit j, input bit b, input bit z);
    int p1, op, imm;
    p1  = (int'(p) + 1) % 65536;
    op  = int'(ir) / 4096;
    imm = int'(ir) % 16;
    if (imm >= 8) imm -= 16;
    if (j) return 16'((p1 / 4096) * 4096 + int'(ir) % 4096);
    if (b && ((op == 4 && z) || (op == 5 && !z)))
      return 16'((p1 + imm + 65536) % 65536);
    return 16'(p1);
  endfunction

  task automatic do_fetch(input logic [15:0] ir, input bit j,
      input bit b, input bit z, input int gd, input int rd,
      input int hold, input logic [15:0] exp_nx, input string nm);
    int n;
    int lat;
    bit stable;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk({nm, "_req_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_addr"}, imem_addr, m_pc);
    lat = 0;
    stable = 1;
    for (int i = 0; i < gd; i++) begin
      retire = 1; jump_i = 1;
      imem_rvalid = 1; imem_rdata = ~ir;
      @(negedge clk);
      lat++;
      retire = 0; jump_i = 0; imem_rvalid = 0;
      if (!imem_req || imem_addr !== m_pc) stable = 0;
    end
    if (gd > 0) chk({nm, "_addr_stable"}, 32'(stable), 1);
    imem_gnt = 1;
    @(negedge clk);
    lat++;
    imem_gnt = 0;
    for (int i = 0; i < rd; i++) begin
      imem_gnt = 1; retire = 1;
      @(negedge clk);
      lat++;
      imem_gnt = 0; retire = 0;
    end
    imem_rvalid = 1; imem_rdata = ir;
    @(negedge clk);
    lat++;
    imem_rvalid = 0; imem_rdata = ~ir;
    n = 0;
    while (!instr_valid && n < 10) begin
      @(negedge clk);
      lat++;
      n++;
    end
    chk({nm, "_latency"}, lat, 2 + gd + rd);
    chk({nm, "_instr"}, {instr, pc}, {ir, m_pc});
    chk({nm, "_fields"}, {opcode, funct},
        {4'(int'(ir) / 4096), 4'(int'(ir) % 16)});
    for (int h = 0; h < hold; h++) begin
      if (h % 2 == 0) imem_gnt = 1;
      else imem_rvalid = 1;
      @(negedge clk);
      imem_gnt = 0; imem_rvalid = 0;
    end
    if (hold > 0)
      chk({nm, "_hold"}, {instr_valid, imem_req, instr, pc},
          {1'b1, 1'b0, ir, m_pc});
    jump_i = j; branch_i = b; zero_i = z; retire = 1;
    @(negedge clk);
    retire = 0; jump_i = 0; branch_i = 0; zero_i = 0;
    chk({nm, "_next"}, {instr_valid, imem_req, imem_addr},
        {1'b0, 1'b1, exp_nx});
    m_pc = exp_nx;
  endtask

  task automatic goto_pc(input logic [15:0] t);
    logic [15:0] p1;
    logic [15:0] ir;
    int guard;
    guard = 0;
    while (m_pc != t && guard < 64) begin
      guard++;
      p1 = m_pc + 16'd1;
      if (p1[15:12] == t[15:12]) begin
        ir = {4'h6, t[11:0]};
        do_fetch(ir, 1, 0, 0, 0, 0, 0, ref_next(m_pc, ir, 1, 0, 0), "nav");
      end else if (m_pc[11:0] != 12'hFFF) begin
        ir = 16'h6FFF;
        do_fetch(ir, 1, 0, 0, 0, 0, 0, ref_next(m_pc, ir, 1, 0, 0), "nav");
      end else begin
        ir = 16'h0000;
        do_fetch(ir, 0, 0, 0, 0, 0, 0, ref_next(m_pc, ir, 0, 0, 0), "nav");
      end
    end
    chk("nav_reached", m_pc, t);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] ir;
    bit j, b, z;
    int n;

    tbl[0] = '{16'h0010, 16'h400E, 0, 1, 1, 16'h000F};
    tbl[1] = '{16'h0010, 16'h400E, 0, 1, 0, 16'h0011};
    tbl[2] = '{16'h0010, 16'h500E, 0, 1, 0, 16'h000F};
    tbl[3] = '{16'h0010, 16'h500E, 0, 1, 1, 16'h0011};
    tbl[4] = '{16'h3FFF, 16'h6ABC, 1, 1, 0, 16'h4ABC};
    tbl[5] = '{16'hFFFF, 16'h0000, 0, 0, 0, 16'h0000};
    tbl[6] = '{16'h0020, 16'h4007, 0, 1, 1, 16'h0028};
    tbl[7] = '{16'h0020, 16'h7FFE, 0, 1, 1, 16'h0021};
    tbl[8] = '{16'hFFFF, 16'h4001, 0, 1, 1, 16'h0001};
    tbl[9] = '{16'h0005, 16'h400F, 0, 0, 1, 16'h0006};

    rst_n = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    retire = 0; branch_i = 0; jump_i = 0; zero_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs",
        {imem_req, instr_valid, imem_addr, pc},
        {1'b0, 1'b0, 16'h0000, 16'h0000});
    chk("rst_instr", instr, 16'h0000);
    rst_n = 1;
    @(negedge clk);
    chk("req_after_rst", {imem_req, imem_addr}, {1'b1, 16'h0000});
    m_pc = 16'h0000;

    do_fetch(16'h0123, 0, 0, 0, 0, 0, 0, 16'h0001, "zero_wait");
    do_fetch(16'h7123, 0, 1, 1, 3, 2, 4, 16'h0002, "delayed");

    for (int i = 0; i < 10; i++) begin
      goto_pc(tbl[i].pc);
      do_fetch(tbl[i].ir, tbl[i].j, tbl[i].b, tbl[i].z,
               i % 3, (i + 1) % 3, (i % 2) * 2, tbl[i].nx,
               $sformatf("vec%0d", i));
    end

    goto_pc(16'h1234);
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_req_seen", imem_req, 1);
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    rst_n = 0;
    #1;
    chk("async_rst",
        {imem_req, instr_valid, imem_addr, pc, instr},
        {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000});
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("restart_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    m_pc = 16'h0000;
    do_fetch(16'h3456, 0, 0, 0, 1, 0, 1, 16'h0001, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ir = 16'($urandom);
      ir[15:12] = 4'($urandom_range(0, 7));
      j = ($urandom_range(0, 3) == 0);
      b = 1'($urandom);
      z = 1'($urandom);
      do_fetch(ir, j, b, z, $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 3), ref_next(m_pc, ir, j, b, z),
               $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
